// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - status-bus inputs and 7-segment outputs of seg_scan_driver
interface seg_scan_driver_if;
    logic [15:0] dataBus;
    logic        hold;
    logic [3:0]  dp_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    modport master (
        output dataBus, hold, dp_mask,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  dataBus, hold, dp_mask,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - 4-digit multiplexed 7-segment driver with frame-coherent shadow; SEG_SCAN_BLANK_EN adds per-slot dead time
module seg_scan_driver #(
    parameter int SCAN_DIV  = 53,
    parameter int BLANK_CYC = 4
) (
    input  logic            clk10000hz,
    input  logic            reset,
    seg_scan_driver_if.slave bus
);

`ifdef SEG_SCAN_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    localparam logic [7:0] P_LAST  = 8'(SCAN_DIV - 1);
    localparam logic [7:0] P_BLANK = 8'(BLANK_CYC);

    logic [7:0]  p;
    logic [1:0]  d;
    logic [15:0] sh;
    logic        load_pend;

    logic        slot_end;
    logic        load_cyc;
    logic        blank;
    logic [3:0]  nib;
    logic [6:0]  seg_dec;
    logic [3:0]  an_dec;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        slot_end = (p == P_LAST);
        // A pending first load or the last cycle of digit 3 reloads the shadow.
        load_cyc = load_pend || (slot_end && (d == 2'd3));
        blank    = BLANK_EN && (p < P_BLANK);
        case (d)
            2'd0:    nib = sh[3:0];
            2'd1:    nib = sh[7:4];
            2'd2:    nib = sh[11:8];
            default: nib = sh[15:12];
        endcase
        seg_dec = decode(nib);
        an_dec  = ~(4'b0001 << d);
    end

    always_ff @(posedge clk10000hz) begin
        if (!reset) begin
            p              <= 8'd0;
            d              <= 2'd0;
            sh             <= 16'd0;
            load_pend      <= 1'b1;
            bus.an         <= 4'b1111;
            bus.seg        <= 7'b1111111;
            bus.dp         <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            if (slot_end) begin
                p <= 8'd0;
                d <= d + 2'd1;
            end else begin
                p <= p + 8'd1;
            end

            // A held load is simply skipped; the next chance is the next wrap.
            if (load_cyc && !bus.hold) begin
                sh             <= bus.dataBus;
                load_pend      <= 1'b0;
                bus.frame_done <= 1'b1;
            end else begin
                bus.frame_done <= 1'b0;
            end

            if (blank) begin
                bus.an  <= 4'b1111;
                bus.seg <= 7'b1111111;
                bus.dp  <= 1'b1;
            end else begin
                bus.an  <= an_dec;
                bus.seg <= seg_dec;
                bus.dp  <= ~bus.dp_mask[d];
            end
        end
    end

endmodule
